ecb_block_assembler: RTL and testbench
======================================

# ecb_block_assembler

Upstream stage of the ECB XOR cipher. Accepts a byte stream over a valid/ready handshake and packs the bytes into SYNC_SIZE-bit blocks, first byte in bits [7:0]. A short final block is completed with PKCS#7-style padding. Each finished block is presented on a valid/ready output port; its data feeds the cipher's plaintext input, and its valid qualifies the cipher's enable.

## Interface
- SYNC_SIZE, 128: block width in bits.
  - Must be a multiple of 8.
  - Must be 8..2040, so NB = SYNC_SIZE/8 is at most 255.
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  input byte.
- in_valid  in  1  in_data is valid this cycle.
- in_last  in  1  qualifies in_data as the last byte of the message.
- in_ready  out  1  block can accept a byte this cycle.
- blk_data  out  SYNC_SIZE  assembled block.
- blk_valid  out  1  blk_data, blk_last and blk_pad are valid.
- blk_ready  in  1  downstream accepts the block.
- blk_last  out  1  block contains the message's last byte.
- blk_pad  out  8  number of pad bytes in the block (0..NB-1).

## Operation
- Byte acceptance:
  - A byte is accepted when in_valid && in_ready.
  - Accepted byte k (0-based within the block) is written to blk_data[8k+7:8k].
- Internal byte counter cnt:
  - Width is clog2(NB+1).
  - Resets to 0.
  - Increments on each accepted byte.
- State machine with 2 states, reset state FILL:
  - FILL: in_ready=1, blk_valid=0.
    - On acceptance with cnt==NB-1 (block full): go to HOLD with blk_pad=0 and blk_last=in_last.
    - On acceptance with in_last=1 and cnt<NB-1: go to HOLD with P=NB-1-cnt. Bytes cnt+1..NB-1 are all set to value P in the same edge, blk_pad=P and blk_last=1.
    - Otherwise stay in FILL.
  - HOLD: in_ready=0, blk_valid=1; blk_data, blk_pad and blk_last are stable.
    - On blk_ready=1: go to FILL, cnt=0, blk_last=0, blk_pad=0.
    - Otherwise stay in HOLD.
- A message that ends exactly on a block boundary produces no extra pad block. That block has blk_last=1 and blk_pad=0.
- in_last while in HOLD is ignored, because no byte is accepted.
- in_data, in_last and blk_ready are don't-care when not qualified.
- blk_data keeps bytes from the previous block in positions not yet rewritten during FILL. Downstream only samples blk_data when blk_valid=1.

## Timing
- Reset values:
  - State=FILL, cnt=0.
  - blk_data=0, blk_valid=0, blk_last=0, blk_pad=0.
  - in_ready=1 in the first cycle after rst is released.
- in_ready and blk_valid are decoded from state only, with no combinational path from any input to any output.
- Latency: blk_valid asserts in the cycle after the edge that accepted the completing byte.
- Output handshake: the block transfers on the edge where blk_valid && blk_ready.
  - in_ready returns to 1 in the next cycle, so there is one bubble per block.
  - Throughput is NB bytes per NB+1 cycles with blk_ready held at 1.
- blk_ready=1 while in FILL has no effect.
- rst asserted in any state, including mid-block or in HOLD with blk_ready=1: the partial block is discarded and all reset values apply on that edge. Reset has priority over every other event.

## Test plan
All scenarios use SYNC_SIZE=32 (NB=4).
- Full block:
  - Stimulus: bytes 0x11, 0x22, 0x33, 0x44 back-to-back, in_last=0 throughout, blk_ready=1.
  - Required: exactly one cycle with blk_valid=1, blk_data=0x44332211, blk_pad=0, blk_last=0. in_ready=0 in that cycle.
- Short last block:
  - Stimulus: 0xAA, then 0xBB with in_last=1.
  - Required: blk_data=0x0202BBAA, blk_pad=2, blk_last=1.
- Single-byte message:
  - Stimulus: 0x5C with in_last=1.
  - Required: blk_data=0x0303035C, blk_pad=3, blk_last=1.
- Backpressure:
  - Stimulus: complete the block 0x04030201, hold blk_ready=0 for 5 cycles, and hold in_valid=1 with 0xFF throughout.
  - Required: blk_data is stable and in_ready=0 for all 5 cycles. 0xFF is not accepted until the cycle after blk_ready=1. The next block then begins with byte 0xFF.
- Boundary last: four bytes 0x01..0x04 with in_last on the 4th -> blk_data=0x04030201, blk_pad=0, blk_last=1, and no further block follows.
- Reset mid-block:
  - Stimulus: accept 0x10 and 0x20, pulse rst for 1 cycle, then send 0x31, 0x32, 0x33, 0x34.
  - Required: blk_data=0x34333231 with no trace of 0x10 or 0x20. All outputs hold their reset values in the cycle after the rst edge.

Source files
------------

// File: rtl/ecb_block_assembler_if.sv
// Byte-in / block-out handshake bundle for ecb_block_assembler.
// master: assembler side (takes bytes, drives blocks); slave: its environment.
interface ecb_block_assembler_if #(
   parameter int SYNC_SIZE = 128
);
   logic [7:0]           in_data;
   logic                 in_valid;
   logic                 in_last;
   logic                 in_ready;
   logic [SYNC_SIZE-1:0] blk_data;
   logic                 blk_valid;
   logic                 blk_ready;
   logic                 blk_last;
   logic [7:0]           blk_pad;

   modport master (
      input  in_data, in_valid, in_last, blk_ready,
      output in_ready, blk_data, blk_valid, blk_last, blk_pad
   );

   modport slave (
      output in_data, in_valid, in_last, blk_ready,
      input  in_ready, blk_data, blk_valid, blk_last, blk_pad
   );
endinterface

// File: rtl/ecb_block_assembler.sv
// Packs a byte stream into SYNC_SIZE-bit blocks (first byte in [7:0]) and
// pads a short final block PKCS#7-style. Ports: clk, rst (sync, high), bus.
module ecb_block_assembler #(
   parameter int SYNC_SIZE = 128
) (
   input logic                  clk,
   input logic                  rst,
   ecb_block_assembler_if.master bus
);
   localparam int NB = SYNC_SIZE / 8;
   localparam int CW = $clog2(NB + 1);

   typedef enum logic {FILL, HOLD} state_t;

   state_t               state_q, state_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic [SYNC_SIZE-1:0] data_q, data_d;
   logic                 last_q, last_d;
   logic [7:0]           pad_q, pad_d;

   logic                 acc;
   logic                 full;
   logic [7:0]           pad_val;

   assign acc     = (state_q == FILL) && bus.in_valid;
   assign full    = (cnt_q == CW'(NB - 1));
   assign pad_val = 8'(NB - 1 - int'(cnt_q));

   // state register (plus datapath flops)
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FILL;
         cnt_q   <= '0;
         data_q  <= '0;
         last_q  <= 1'b0;
         pad_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         last_q  <= last_d;
         pad_q   <= pad_d;
      end
   end

   // next-state
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         FILL: if (acc && (full || bus.in_last)) state_d = HOLD;
         HOLD: if (bus.blk_ready) state_d = FILL;
         default: state_d = FILL;
      endcase
   end

   // datapath next values
   always_comb begin
      cnt_d  = cnt_q;
      data_d = data_q;
      last_d = last_q;
      pad_d  = pad_q;
      if (acc) begin
         data_d[8*cnt_q +: 8] = bus.in_data;
         cnt_d = cnt_q + CW'(1);
         if (full) begin
            pad_d  = 8'd0;
            last_d = bus.in_last;
         end else if (bus.in_last) begin
            // fill every byte above the current one with the pad count
            for (int j = 0; j < NB; j++) begin
               if (j > int'(cnt_q)) data_d[8*j +: 8] = pad_val;
            end
            pad_d  = pad_val;
            last_d = 1'b1;
         end
      end else if (state_q == HOLD && bus.blk_ready) begin
         cnt_d  = '0;
         last_d = 1'b0;
         pad_d  = 8'd0;
      end
   end

   // outputs, decoded from state and flops only
   always_comb begin
      bus.in_ready  = (state_q == FILL);
      bus.blk_valid = (state_q == HOLD);
      bus.blk_data  = data_q;
      bus.blk_last  = last_q;
      bus.blk_pad   = pad_q;
   end
endmodule

// File: tb/tb_ecb_block_assembler.sv
// Directed bench for ecb_block_assembler with SYNC_SIZE=32 (NB=4).
// Inputs change #1 after posedge or at negedge; outputs sampled at negedge.
module tb_ecb_block_assembler;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   ecb_block_assembler_if #(.SYNC_SIZE(32)) bus ();

   ecb_block_assembler #(.SYNC_SIZE(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic feed(input logic [7:0] b, input logic l);
      bus.in_valid = 1'b1;
      bus.in_data  = b;
      bus.in_last  = l;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.in_last  = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_data   = 8'h00;
      bus.in_last   = 1'b0;
      bus.blk_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_in_ready got %b want 1", bus.in_ready);
      end
      checks++;
      if (bus.blk_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_blk_valid got %b want 0", bus.blk_valid);
      end
      checks++;
      if (bus.blk_data !== 32'h0) begin
         errors++;
         $display("FAIL reset_blk_data got %h want 0", bus.blk_data);
      end
      checks++;
      if (bus.blk_last !== 1'b0 || bus.blk_pad !== 8'd0) begin
         errors++;
         $display("FAIL reset_last_pad got %b/%0d want 0/0",
                  bus.blk_last, bus.blk_pad);
      end
   endtask

   task automatic test_full_block();
      bus.blk_ready = 1'b1;
      feed(8'h11, 1'b0);
      feed(8'h22, 1'b0);
      feed(8'h33, 1'b0);
      feed(8'h44, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL full_hs got valid=%b ready=%b want 1/0",
                  bus.blk_valid, bus.in_ready);
      end
      checks++;
      if (bus.blk_data !== 32'h44332211) begin
         errors++;
         $display("FAIL full_data got %h want 44332211", bus.blk_data);
      end
      checks++;
      if (bus.blk_pad !== 8'd0 || bus.blk_last !== 1'b0) begin
         errors++;
         $display("FAIL full_pad_last got %0d/%b want 0/0",
                  bus.blk_pad, bus.blk_last);
      end
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL full_one_cycle got valid=%b ready=%b want 0/1",
                  bus.blk_valid, bus.in_ready);
      end
   endtask

   task automatic test_short_last();
      feed(8'hAA, 1'b0);
      feed(8'hBB, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== 32'h0202BBAA) begin
         errors++;
         $display("FAIL short_data got v=%b %h want 1 0202bbaa",
                  bus.blk_valid, bus.blk_data);
      end
      checks++;
      if (bus.blk_pad !== 8'd2 || bus.blk_last !== 1'b1) begin
         errors++;
         $display("FAIL short_pad_last got %0d/%b want 2/1",
                  bus.blk_pad, bus.blk_last);
      end
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b0 || bus.blk_pad !== 8'd0
          || bus.blk_last !== 1'b0) begin
         errors++;
         $display("FAIL short_release got v=%b pad=%0d last=%b want 0/0/0",
                  bus.blk_valid, bus.blk_pad, bus.blk_last);
      end
   endtask

   task automatic test_single_byte();
      feed(8'h5C, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== 32'h0303035C) begin
         errors++;
         $display("FAIL single_data got v=%b %h want 1 0303035c",
                  bus.blk_valid, bus.blk_data);
      end
      checks++;
      if (bus.blk_pad !== 8'd3 || bus.blk_last !== 1'b1) begin
         errors++;
         $display("FAIL single_pad_last got %0d/%b want 3/1",
                  bus.blk_pad, bus.blk_last);
      end
      @(negedge clk);
   endtask

   task automatic test_backpressure();
      int bad;
      bus.blk_ready = 1'b0;
      feed(8'h01, 1'b0);
      feed(8'h02, 1'b0);
      feed(8'h03, 1'b0);
      feed(8'h04, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_data  = 8'hFF;
      bus.in_last  = 1'b0;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (bus.blk_valid !== 1'b1 || bus.in_ready !== 1'b0
             || bus.blk_data !== 32'h04030201) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL bp_hold got %0d bad cycles want 0", bad);
      end
      bus.blk_ready = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL bp_release got v=%b r=%b want 0/1",
                  bus.blk_valid, bus.in_ready);
      end
      @(posedge clk);
      #1;
      feed(8'hA1, 1'b0);
      feed(8'hA2, 1'b0);
      feed(8'hA3, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== 32'hA3A2A1FF) begin
         errors++;
         $display("FAIL bp_next_block got v=%b %h want 1 a3a2a1ff",
                  bus.blk_valid, bus.blk_data);
      end
      checks++;
      if (bus.blk_pad !== 8'd0 || bus.blk_last !== 1'b1) begin
         errors++;
         $display("FAIL bp_next_pad_last got %0d/%b want 0/1",
                  bus.blk_pad, bus.blk_last);
      end
      @(negedge clk);
   endtask

   task automatic test_boundary_last();
      int extra;
      feed(8'h01, 1'b0);
      feed(8'h02, 1'b0);
      feed(8'h03, 1'b0);
      feed(8'h04, 1'b1);
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== 32'h04030201) begin
         errors++;
         $display("FAIL bound_data got v=%b %h want 1 04030201",
                  bus.blk_valid, bus.blk_data);
      end
      checks++;
      if (bus.blk_pad !== 8'd0 || bus.blk_last !== 1'b1) begin
         errors++;
         $display("FAIL bound_pad_last got %0d/%b want 0/1",
                  bus.blk_pad, bus.blk_last);
      end
      extra = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.blk_valid === 1'b1) extra++;
      end
      checks++;
      if (extra != 0) begin
         errors++;
         $display("FAIL bound_no_extra got %0d valid cycles want 0", extra);
      end
   endtask

   task automatic test_reset_mid_block();
      feed(8'h10, 1'b0);
      feed(8'h20, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.blk_data !== 32'h0 || bus.blk_valid !== 1'b0
          || bus.in_ready !== 1'b1 || bus.blk_pad !== 8'd0
          || bus.blk_last !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_state got d=%h v=%b r=%b p=%0d l=%b want 0/0/1/0/0",
                  bus.blk_data, bus.blk_valid, bus.in_ready,
                  bus.blk_pad, bus.blk_last);
      end
      feed(8'h31, 1'b0);
      feed(8'h32, 1'b0);
      feed(8'h33, 1'b0);
      feed(8'h34, 1'b0);
      @(negedge clk);
      checks++;
      if (bus.blk_valid !== 1'b1 || bus.blk_data !== 32'h34333231) begin
         errors++;
         $display("FAIL rstmid_data got v=%b %h want 1 34333231",
                  bus.blk_valid, bus.blk_data);
      end
      checks++;
      if (bus.blk_pad !== 8'd0 || bus.blk_last !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_pad_last got %0d/%b want 0/0",
                  bus.blk_pad, bus.blk_last);
      end
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_full_block();
      test_short_last();
      test_single_byte();
      test_backpressure();
      test_boundary_last();
      test_reset_mid_block();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
